// File: rtl/dense_layer_engine_if.sv
// dense_layer_engine_if
//   Memory read ports and result stream of the dense layer engine.
//   master : engine side (drives addresses/enables and the result stream)
//   slave  : memory models and result consumer
//   act_*  : activation RAM, 1-cycle read latency
//   wgt_*  : weight ROM, packed as c*in_size + i, 1-cycle read latency
//   bias_* : bias ROM, 1-cycle read latency
//   out_*  : valid/ready result stream (data, raw accumulator, channel)
interface dense_layer_engine_if #(
  parameter int MAX_IN  = 256,
  parameter int MAX_OUT = 64,
  parameter int ACC_W   = 32
);
  localparam int AAW = $clog2(MAX_IN);
  localparam int WAW = $clog2(MAX_IN*MAX_OUT);
  localparam int BAW = $clog2(MAX_OUT);

  logic [AAW-1:0]          act_addr;
  logic                    act_re;
  logic signed [7:0]       act_rdata;
  logic [WAW-1:0]          wgt_addr;
  logic                    wgt_re;
  logic signed [7:0]       wgt_rdata;
  logic [BAW-1:0]          bias_addr;
  logic                    bias_re;
  logic signed [ACC_W-1:0] bias_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [7:0]       out_data;
  logic signed [ACC_W-1:0] out_acc;
  logic [BAW-1:0]          out_channel;

  modport master (
    output act_addr, act_re, input act_rdata,
    output wgt_addr, wgt_re, input wgt_rdata,
    output bias_addr, bias_re, input bias_rdata,
    output out_valid, out_data, out_acc, out_channel, input out_ready
  );

  modport slave (
    input act_addr, act_re, output act_rdata,
    input wgt_addr, wgt_re, output wgt_rdata,
    input bias_addr, bias_re, output bias_rdata,
    input out_valid, out_data, out_acc, out_channel, output out_ready
  );
endinterface

// File: rtl/dense_layer_engine.sv
// dense_layer_engine
//   Fully-connected layer, one output channel at a time:
//   out[c] = requant(bias[c] + sum_i (act[i] - input_zp) * w[c][i])
//   Ports:
//     clk, reset_n       : clock, asynchronous active-low reset
//     start              : single-cycle start, ignored while busy
//     cfg_*              : layer config, latched on an accepted start
//     bus (master)       : activation/weight/bias reads, result stream
//     busy               : high from the cycle after start until done
//     done               : one-cycle pulse after the last channel is accepted
module dense_layer_engine #(
  parameter int MAX_IN  = 256,
  parameter int MAX_OUT = 64,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [$clog2(MAX_IN+1)-1:0]    cfg_in_size,
  input  logic [$clog2(MAX_OUT+1)-1:0]   cfg_out_size,
  input  logic signed [7:0]              cfg_input_zp,
  input  logic signed [7:0]              cfg_output_zp,
  input  logic signed [31:0]             cfg_mult,
  input  logic [SHIFT_W-1:0]             cfg_shift,
  input  logic                           cfg_relu,
  dense_layer_engine_if.master           bus,
  output logic                           busy,
  output logic                           done
);
  localparam int ISW = $clog2(MAX_IN+1);
  localparam int OSW = $clog2(MAX_OUT+1);
  localparam int AAW = $clog2(MAX_IN);
  localparam int WAW = $clog2(MAX_IN*MAX_OUT);
  localparam int BAW = $clog2(MAX_OUT);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_RQ, S_OUT, S_FIN} state_t;
  state_t state, state_nxt;

  logic [ISW-1:0]          in_size, k, in_clamp;
  logic [OSW-1:0]          out_size, out_clamp;
  logic [BAW-1:0]          c;
  logic [WAW-1:0]          wbase;     // c*in_size, advanced per channel
  logic signed [7:0]       izp, ozp;
  logic signed [31:0]      mult;
  logic [SHIFT_W-1:0]      shift;
  logic                    relu;
  logic signed [ACC_W-1:0] acc;
  logic signed [7:0]       y_q;
  logic                    last_ch, mac_rd;
  logic                    act_re_c, wgt_re_c, bias_re_c, out_valid_c;

  assign in_clamp  = (cfg_in_size > ISW'(MAX_IN)) ? ISW'(MAX_IN) : cfg_in_size;
  assign out_clamp = (cfg_out_size > OSW'(MAX_OUT)) ? OSW'(MAX_OUT) : cfg_out_size;
  assign last_ch   = ((OSW'(c) + OSW'(1)) == out_size);
  assign mac_rd    = (k < in_size);

  // MAC term: 9-bit difference, 17-bit product, sign-extended into the accumulator
  logic signed [8:0]  diff;
  logic signed [16:0] prod;
  assign diff = $signed({bus.act_rdata[7], bus.act_rdata}) - $signed({izp[7], izp});
  assign prod = diff * bus.wgt_rdata;

  // Requantisation in 64-bit signed arithmetic, round half up
  logic signed [63:0] p, rnd, r, y;
  logic [6:0]         sh;
  logic signed [7:0]  y_sat, y_rq;
  always_comb begin
    p     = $signed({{(64-ACC_W){acc[ACC_W-1]}}, acc}) * $signed({{32{mult[31]}}, mult});
    sh    = 7'd31 + 7'(shift);
    rnd   = 64'sd1 <<< (sh - 7'd1);
    r     = (p + rnd) >>> sh;
    y     = r + $signed({{56{ozp[7]}}, ozp});
    y_sat = y[7:0];
    if (y > 64'sd127)       y_sat = 8'sd127;
    else if (y < -64'sd128) y_sat = -8'sd128;
    y_rq  = (relu && (y_sat < ozp)) ? ozp : y_sat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    act_re_c    = 1'b0;
    wgt_re_c    = 1'b0;
    bias_re_c   = 1'b0;
    out_valid_c = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nxt = (out_clamp == '0) ? S_FIN : S_BIAS;
      S_BIAS: begin
        bias_re_c = 1'b1;
        state_nxt = S_MAC;
      end
      S_MAC: begin
        act_re_c = mac_rd;
        wgt_re_c = mac_rd;
        if (k == in_size) state_nxt = S_RQ;
      end
      S_RQ:   state_nxt = S_OUT;
      S_OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = last_ch ? S_FIN : S_BIAS;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_size  <= '0;
      out_size <= '0;
      izp      <= '0;
      ozp      <= '0;
      mult     <= '0;
      shift    <= '0;
      relu     <= 1'b0;
      k        <= '0;
      c        <= '0;
      wbase    <= '0;
      acc      <= '0;
      y_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          in_size  <= in_clamp;
          out_size <= out_clamp;
          izp      <= cfg_input_zp;
          ozp      <= cfg_output_zp;
          mult     <= cfg_mult;
          shift    <= cfg_shift;
          relu     <= cfg_relu;
          c        <= '0;
          wbase    <= '0;
          k        <= '0;
        end
        S_BIAS: k <= '0;
        S_MAC: begin
          // k=0 consumes the bias read; k>=1 consumes the act/wgt read from k-1
          if (k == '0) acc <= bus.bias_rdata;
          else         acc <= acc + {{(ACC_W-17){prod[16]}}, prod};
          if (mac_rd)  k <= k + ISW'(1);
        end
        S_RQ: y_q <= y_rq;
        S_OUT: if (bus.out_ready && !last_ch) begin
          c     <= c + BAW'(1);
          wbase <= wbase + WAW'(in_size);
        end
        default: ;
      endcase
    end
  end

  assign bus.act_re      = act_re_c;
  assign bus.act_addr    = k[AAW-1:0];
  assign bus.wgt_re      = wgt_re_c;
  assign bus.wgt_addr    = wbase + WAW'(k);
  assign bus.bias_re     = bias_re_c;
  assign bus.bias_addr   = c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = y_q;
  assign bus.out_acc     = acc;
  assign bus.out_channel = c;
endmodule

// File: tb/tb_dense_layer_engine.sv
// tb_dense_layer_engine
//   Directed vectors with hand-computed expectations for dense_layer_engine.
//   Memories are 1-cycle-latency models; a negedge monitor records accepted
//   results, read counts, done pulses and the BIAS-to-valid latency.
module tb_dense_layer_engine;
  localparam int MAX_IN = 256, MAX_OUT = 64, ACC_W = 32, SHIFT_W = 5;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [$clog2(MAX_IN+1)-1:0]  cfg_in_size = '0;
  logic [$clog2(MAX_OUT+1)-1:0] cfg_out_size = '0;
  logic signed [7:0]  cfg_input_zp = '0, cfg_output_zp = '0;
  logic signed [31:0] cfg_mult = '0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic cfg_relu = 1'b0;
  logic busy, done;

  dense_layer_engine_if #(.MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .ACC_W(ACC_W)) bus();

  dense_layer_engine #(.MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_in_size(cfg_in_size), .cfg_out_size(cfg_out_size),
    .cfg_input_zp(cfg_input_zp), .cfg_output_zp(cfg_output_zp),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .bus(bus.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic signed [7:0]       act_mem  [MAX_IN];
  logic signed [7:0]       wgt_mem  [MAX_IN*MAX_OUT];
  logic signed [ACC_W-1:0] bias_mem [MAX_OUT];

  always @(posedge clk) begin
    if (bus.act_re)  bus.act_rdata  <= act_mem[bus.act_addr];
    if (bus.wgt_re)  bus.wgt_rdata  <= wgt_mem[bus.wgt_addr];
    if (bus.bias_re) bus.bias_rdata <= bias_mem[bus.bias_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_act, n_wgt, n_bias, n_done, first_bias, first_valid;
  longint res_acc[$], res_data[$], res_ch[$];

  always @(negedge clk) begin
    if (bus.act_re)  n_act++;
    if (bus.wgt_re)  n_wgt++;
    if (bus.bias_re) n_bias++;
    if (done)        n_done++;
    if (bus.bias_re && first_bias < 0)   first_bias = cyc;
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (bus.out_valid && bus.out_ready) begin
      res_acc.push_back(longint'(bus.out_acc));
      res_data.push_back(longint'(bus.out_data));
      res_ch.push_back(longint'(bus.out_channel));
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_act = 0; n_wgt = 0; n_bias = 0; n_done = 0;
    first_bias = -1; first_valid = -1;
    res_acc.delete(); res_data.delete(); res_ch.delete();
  endtask

  task automatic cfg_set(input int isz, input int osz, input int izp, input int ozp,
                         input longint m, input int sh, input bit rl);
    cfg_in_size   = ($clog2(MAX_IN+1))'(isz);
    cfg_out_size  = ($clog2(MAX_OUT+1))'(osz);
    cfg_input_zp  = 8'(izp);
    cfg_output_zp = 8'(ozp);
    cfg_mult      = 32'(m);
    cfg_shift     = SHIFT_W'(sh);
    cfg_relu      = rl;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) begin
      act_mem[i]   = 8'(i + 1);
      wgt_mem[i]   = 8'sd1;
      wgt_mem[4+i] = 8'(-(i + 1));
    end
    bias_mem[0] = 10;
    bias_mem[1] = -5;
  endtask

  task automatic check_basic(input string tag);
    chk({tag, "_n"},    res_data.size(), 2);
    chk({tag, "_acc0"}, res_acc[0], 20);
    chk({tag, "_acc1"}, res_acc[1], -35);
    chk({tag, "_dat0"}, res_data[0], 10);
    chk({tag, "_dat1"}, res_data[1], -17);
    chk({tag, "_ch0"},  res_ch[0], 0);
    chk({tag, "_ch1"},  res_ch[1], 1);
    chk({tag, "_done"}, n_done, 1);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    for (int i = 0; i < MAX_IN; i++) act_mem[i] = '0;
    for (int i = 0; i < MAX_IN*MAX_OUT; i++) wgt_mem[i] = '0;
    for (int i = 0; i < MAX_OUT; i++) bias_mem[i] = '0;
    clr();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_re",    {bus.act_re, bus.wgt_re, bus.bias_re}, 0);
    chk("rst_data",  bus.out_data, 0);
    chk("rst_acc",   bus.out_acc, 0);
    chk("rst_ch",    bus.out_channel, 0);
    reset_n = 1'b1;

    // basic two-channel layer
    load_basic();
    cfg_set(4, 2, 0, 0, 64'd1 << 30, 0, 0);
    clr(); pulse_start(); wait_done(200); settle();
    check_basic("basic");
    chk("basic_lat",  first_valid - first_bias, 7);
    chk("basic_busy", busy, 0);

    // relu with output zero point
    cfg_set(4, 2, 0, 3, 64'd1 << 30, 0, 1);
    clr(); pulse_start(); wait_done(200); settle();
    chk("relu_dat0", res_data[0], 13);
    chk("relu_dat1", res_data[1], 3);

    // saturation, in_size=0 means acc = bias
    bias_mem[0] = 1000;
    cfg_set(0, 1, 0, 0, 64'd1 << 30, 0, 0);
    clr(); pulse_start(); wait_done(200); settle();
    chk("satp_acc",  res_acc[0], 1000);
    chk("satp_dat",  res_data[0], 127);
    chk("satp_reads", n_act + n_wgt, 0);
    bias_mem[0] = -1000;
    clr(); pulse_start(); wait_done(200); settle();
    chk("satn_dat",  res_data[0], -128);

    // input zero point with near-unity multiplier
    act_mem[0] = 0; wgt_mem[0] = 5; bias_mem[0] = 0;
    cfg_set(1, 1, -2, 0, 64'd2147483647, 0, 0);
    clr(); pulse_start(); wait_done(200); settle();
    chk("zp_acc", res_acc[0], 10);
    chk("zp_dat", res_data[0], 10);

    // backpressure on channel 0
    load_basic();
    cfg_set(4, 2, 0, 0, 64'd1 << 30, 0, 0);
    clr();
    bus.out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 50 && !bus.out_valid; i++) settle();
    chk("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data",  bus.out_data, 10);
      chk("bp_ch",    bus.out_channel, 0);
    end
    chk("bp_reads", n_act + n_wgt + n_bias, 9);
    bus.out_ready = 1'b1;
    wait_done(200); settle();
    check_basic("bp");
    chk("bp_reads_tot", n_act + n_wgt + n_bias, 18);

    // zero output channels
    cfg_set(4, 0, 0, 0, 64'd1 << 30, 0, 0);
    clr(); pulse_start();
    @(negedge clk);
    chk("z_done", done, 1);
    settle();
    chk("z_done_off", done, 0);
    chk("z_busy",   busy, 0);
    chk("z_reads",  n_act + n_wgt + n_bias, 0);
    chk("z_ndone",  n_done, 1);

    // in_size above MAX_IN clamps
    for (int i = 0; i < MAX_IN; i++) begin
      act_mem[i] = 1;
      wgt_mem[i] = 1;
    end
    bias_mem[0] = 0;
    cfg_set(MAX_IN + 7, 1, 0, 0, 64'd1 << 30, 0, 0);
    clr(); pulse_start(); wait_done(600); settle();
    chk("clamp_act", n_act, MAX_IN);
    chk("clamp_wgt", n_wgt, MAX_IN);
    chk("clamp_acc", res_acc[0], 256);
    chk("clamp_dat", res_data[0], 127);

    // start while busy is ignored, cfg changes have no effect
    for (int i = 0; i < MAX_IN; i++) begin
      act_mem[i] = 0;
      wgt_mem[i] = 0;
    end
    load_basic();
    cfg_set(4, 2, 0, 0, 64'd1 << 30, 0, 0);
    clr(); pulse_start();
    repeat (3) settle();
    cfg_set(7, 5, 9, 4, 64'd1 << 29, 2, 1);
    start = 1'b1;
    settle();
    start = 1'b0;
    wait_done(200); settle();
    check_basic("busy_start");
    settle();
    chk("busy_start_idle", busy, 0);

    // async reset during channel 0 MAC
    cfg_set(4, 2, 0, 0, 64'd1 << 30, 0, 0);
    clr(); pulse_start();
    for (int i = 0; i < 20 && !bus.act_re; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_busy",  busy, 0);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_re",    {bus.act_re, bus.wgt_re, bus.bias_re}, 0);
    chk("mrst_acc",   bus.out_acc, 0);
    chk("mrst_data",  bus.out_data, 0);
    repeat (3) settle();
    chk("mrst_ndone", n_done, 0);
    reset_n = 1'b1;
    clr(); pulse_start(); wait_done(200); settle();
    check_basic("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
- Parametrised fully-connected compute engine: out[c] = requant(bias[c] + sum_i (act[i] - input_zp) * w[c][i]), one channel at a time.
- Generalises the fixed 256x64 dense path. Adds runtime sizes up to parameter maxima, per-layer input/output zero points, fixed-point requantisation, optional ReLU and a valid/ready output stream with backpressure.
- Reads activation, weight and bias memories through 1-cycle-latency read ports.
- Sits between tensor RAM / weight ROM / bias ROM and the output tensor writer.

Parameters:
- MAX_IN, 256, maximum input length.
- MAX_OUT, 64, maximum output channels.
- ACC_W, 32, accumulator and bias width (two's complement).
- SHIFT_W, 5, width of the requant right-shift field.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start; ignored while busy
- cfg_in_size  in  $clog2(MAX_IN+1)  input length; values above MAX_IN clamp to MAX_IN
- cfg_out_size  in  $clog2(MAX_OUT+1)  output channels; values above MAX_OUT clamp to MAX_OUT
- cfg_input_zp  in  8  signed input zero point
- cfg_output_zp  in  8  signed output zero point
- cfg_mult  in  32  signed Q31 multiplier
- cfg_shift  in  SHIFT_W  extra right shift
- cfg_relu  in  1  clamp output at or above output_zp
- act_addr  out  $clog2(MAX_IN)  activation read address
- act_re  out  1  activation read enable
- act_rdata  in  8  signed activation; valid the cycle after act_re
- wgt_addr  out  $clog2(MAX_IN*MAX_OUT)  weight read address = c*in_size + i (packed)
- wgt_re  out  1  weight read enable
- wgt_rdata  in  8  signed weight; valid the cycle after wgt_re
- bias_addr  out  $clog2(MAX_OUT)  bias read address
- bias_re  out  1  bias read enable
- bias_rdata  in  ACC_W  signed bias; valid the cycle after bias_re
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  8  signed requantised result
- out_acc  out  ACC_W  raw accumulator for the current channel
- out_channel  out  $clog2(MAX_OUT)  channel index of out_data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last channel is accepted

Behaviour:
- Reset: state IDLE; every output 0; counters and accumulator 0. Reset mid-operation aborts immediately; no done pulse.
- Configuration is latched on an accepted start. cfg_* changes while busy have no effect.
- FSM: IDLE -> BIAS -> MAC -> RQ -> OUT -> (BIAS for next channel | FIN) ; FIN -> IDLE.
- Zero out_size: start sampled -> FIN; done pulses the next cycle with no memory reads.
- IDLE: busy=0. start=1 latches config, sets c=0 and goes to BIAS.
- BIAS (1 cycle): bias_re=1, bias_addr=c.
- MAC (in_size+1 cycles, index k=0..in_size):
  - For k<in_size: act_re=wgt_re=1, act_addr=k, wgt_addr=c*in_size+k.
  - For k=0: acc <= bias_rdata.
  - For k>=1: acc <= acc + (act_rdata - input_zp) * wgt_rdata, using the data returned from the read issued at k-1.
  - The difference is 9-bit signed and the product is 17-bit signed, sign-extended to ACC_W. acc wraps modulo 2^ACC_W.
  - in_size=0 gives 1 MAC cycle, so acc = bias.
- RQ (1 cycle), computed in 64-bit signed arithmetic:
  - p = acc * cfg_mult
  - r = (p + 2^(30+shift)) >>> (31+shift)  (arithmetic shift, round half up)
  - y = r + output_zp
  - Saturate y to [-128,127]. If relu, y = max(y, output_zp) after saturation.
- OUT: out_valid=1; out_data, out_acc and out_channel stay stable until out_valid && out_ready. No memory reads are issued while waiting.
  - On handshake: if c == out_size-1 go to FIN, else c++ and go to BIAS.
  - out_ready high on entry gives a 1-cycle OUT.
- FIN: done=1 for one cycle, busy=0 from the next cycle.
- Latency: BIAS entry to out_valid = in_size+3 cycles per channel, with zero stall.
- At most one of the three read enables is asserted per memory per cycle. Addresses are don't-care when the enable is low.

Test Plan:
- Basic: in_size=4, out_size=2, act=[1,2,3,4], w0=[1,1,1,1], w1=[-1,-2,-3,-4], bias=[10,-5], zps=0, mult=2^30, shift=0, relu=0, out_ready=1.
  - Expect out_acc 20 then -35, out_data 10 then -17, out_channel 0 then 1.
  - out_valid is first seen 7 cycles after BIAS entry; done pulses once.
- ReLU: same stimulus with relu=1 and output_zp=3 -> out_data 13 then 3.
- Saturation and zero point: bias=1000, in_size=0, mult=2^30 -> 127. bias=-1000 -> -128. Input_zp=-2 with act=[0], w=[5], bias 0, mult=2^31-1, shift=0 -> out_acc 10, out_data 10.
- Backpressure: hold out_ready=0 for 5 cycles on channel 0 -> out_valid, out_data and out_channel stable. No act_re/wgt_re/bias_re during the stall. Channel 1 proceeds after the handshake.
- Edge sizes:
  - out_size=0 -> done one cycle after start, no reads.
  - cfg_in_size=MAX_IN+7 -> exactly MAX_IN reads per channel.
  - start pulsed while busy -> ignored, results unchanged.
- Reset mid-MAC: drop reset_n asynchronously during channel 0 MAC -> all outputs 0 immediately. No done pulse. A subsequent start runs cleanly and matches Basic.
